instruction_fetch_unit: RTL and testbench

- Front-end stage directly upstream of `instruction_buffer`.
- Owns the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake.
- Writes each returned instruction into the buffer through its `write_en`/`data_in` port, stalling on the buffer's `is_full`.
- Handles control-flow redirects by discarding in-flight or held instructions and restarting at the new PC.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/instruction_fetch_unit.sv | 68 ++++++
 tb/tb_instruction_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC helpers for the instruction fetch front end.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_HOLD} fetch_state_t;
    localparam int INST_BYTES = 4;
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues one imem request at a time and
// writes each returned instruction into the instruction buffer.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data,
    input  logic                  buf_full
);
    fetch_state_t          state_q, after_write;
    logic [ADDR_WIDTH-1:0] pc_q, redirect_aligned;
    logic [INST_WIDTH-1:0] hold_q;
    logic                  drop_q, accept;

    assign redirect_aligned = ADDR_WIDTH'(align_pc(64'(redirect_pc)));
    assign accept           = state_q == FETCH_REQ && imem_req_ready;
    assign after_write      = fetch_en ? FETCH_REQ : FETCH_IDLE;
    assign imem_req_valid   = state_q == FETCH_REQ;
    assign imem_req_addr    = pc_q;
    // A redirect in the same cycle kills any write, direct or from the hold register.
    assign buf_write_en = !redirect_valid && !buf_full &&
                          ((state_q == FETCH_WAIT && imem_resp_valid && !drop_q) || state_q == FETCH_HOLD);
    assign buf_data = state_q == FETCH_HOLD ? hold_q :
                      (state_q == FETCH_WAIT && imem_resp_valid) ? imem_resp_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: if (!redirect_valid && fetch_en) state_q <= FETCH_REQ;
                FETCH_REQ: if (imem_req_ready) begin
                    state_q <= FETCH_WAIT;
                    drop_q  <= redirect_valid;
                end
                FETCH_WAIT: if (imem_resp_valid) begin
                    drop_q  <= 1'b0;
                    state_q <= (redirect_valid || drop_q) ? FETCH_REQ : buf_full ? FETCH_HOLD : after_write;
                    if (buf_full) hold_q <= imem_resp_data;
                end else if (redirect_valid) begin
                    drop_q <= 1'b1;
                end
                FETCH_HOLD: if (redirect_valid) state_q <= FETCH_REQ;
                            else if (!buf_full) state_q <= after_write;
                default: state_q <= FETCH_IDLE;
            endcase
            if (redirect_valid) pc_q <= redirect_aligned;
            else if (accept) pc_q <= pc_q + ADDR_WIDTH'(INST_BYTES);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a reactive memory model and a write monitor.
module tb_instruction_fetch_unit;
    logic        clk, reset, fetch_en, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        buf_write_en;
    logic [31:0] buf_data;
    logic        buf_full;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          wr_cyc[$];
    int          n_cmp = 0, n_err = 0, n_acc = 0, cyc = 0, mem_delay = 0;
    logic        ovr_valid = 0;
    logic [31:0] ovr_data = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .buf_write_en(buf_write_en),
        .buf_data(buf_data), .buf_full(buf_full)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got=running want=finished");
        $fatal(1, "watchdog");
    end

    // Memory model: samples acceptance mid-cycle, responds mem_delay cycles after the accepting edge.
    initial begin : mem_model
        logic        acc, pend;
        logic [31:0] a, pa, e;
        int          cnt;
        imem_resp_valid = 0;
        imem_resp_data  = 0;
        pend = 0; cnt = 0; a = 0; pa = 0; e = 0;
        forever begin
            @(negedge clk);
            acc = reset && imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 0;
            if (!reset) pend = 0;
            if (acc) begin
                n_acc++;
                n_cmp++;
                if (exp_addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_addr: unexpected request got=%h want=none", a);
                end else begin
                    e = exp_addr_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL req_addr: got=%h want=%h", a, e);
                    end
                end
                pend = 1; pa = a; cnt = mem_delay;
            end
            if (pend) begin
                if (cnt == 0) begin
                    imem_resp_valid = 1;
                    imem_resp_data  = ovr_valid ? ovr_data : data_of(pa);
                    pend = 0;
                end else cnt--;
            end
        end
    end

    // Write monitor: every buffer write must match the next expected instruction.
    initial begin : write_monitor
        logic [31:0] e;
        e = 0;
        forever begin
            @(negedge clk);
            if (buf_write_en) begin
                n_cmp++;
                if (buf_full) begin
                    n_err++;
                    $display("FAIL write_while_full: got=write want=no_write");
                end else if (exp_data_q.size() == 0) begin
                    n_err++;
                    $display("FAIL buf_write: unexpected write got=%h want=none", buf_data);
                end else begin
                    e = exp_data_q.pop_front();
                    if (buf_data !== e) begin
                        n_err++;
                        $display("FAIL buf_write: got=%h want=%h", buf_data, e);
                    end
                end
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int t = 0;
        while (n_acc < n && t < 60) begin
            tick();
            t++;
        end
        if (n_acc < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: accept timeout got=%0d want=%0d", tag, n_acc, n);
        end
    endtask

    task automatic drain(input string tag);
        fetch_en = 0;
        repeat (6) tick();
        @(negedge clk);
        n_cmp++;
        if (exp_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_addr_left: got=%0d want=0", tag, exp_addr_q.size());
        end
        n_cmp++;
        if (exp_data_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_data_left: got=%0d want=0", tag, exp_data_q.size());
        end
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: req_valid got=%b want=0", tag, imem_req_valid);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got=%b want=0", imem_req_valid); end
        n_cmp++;
        if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got=%h want=0", imem_req_addr); end
        n_cmp++;
        if (buf_write_en !== 1'b0) begin n_err++; $display("FAIL rst_write_en: got=%b want=0", buf_write_en); end
        n_cmp++;
        if (buf_data !== 32'h0) begin n_err++; $display("FAIL rst_buf_data: got=%h want=0", buf_data); end
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_zero_wait();
        wr_cyc.delete();
        mem_delay = 0;
        imem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back(data_of(32'(i * 4)));
        end
        fetch_en = 1;
        wait_acc(3, "zero_wait");
        fetch_en = 0;
        drain("zero_wait");
        n_cmp++;
        if (wr_cyc.size() != 3) begin
            n_err++;
            $display("FAIL zero_wait_writes: got=%0d want=3", wr_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (wr_cyc[i] - wr_cyc[i-1] != 2) begin
                    n_err++;
                    $display("FAIL zero_wait_spacing: got=%0d want=2", wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_full_buffer();
        exp_addr_q.push_back(32'hC);
        exp_addr_q.push_back(32'h10);
        exp_data_q.push_back(32'hDEADBEEF);
        exp_data_q.push_back(data_of(32'h10));
        ovr_valid = 1;
        ovr_data  = 32'hDEADBEEF;
        buf_full  = 1;
        fetch_en  = 1;
        wait_acc(4, "full_buffer");
        ovr_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (buf_write_en !== 1'b0) begin n_err++; $display("FAIL full_no_write: got=%b want=0", buf_write_en); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (buf_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL full_hold_data: got=%h want=deadbeef", buf_data); end
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL full_hold_noreq: got=%b want=0", imem_req_valid); end
        tick();
        tick();
        buf_full = 0;
        wait_acc(5, "full_buffer_next");
        drain("full_buffer");
    endtask

    task automatic test_redirect_wait();
        exp_addr_q.push_back(32'h14);
        exp_addr_q.push_back(32'h100);
        exp_data_q.push_back(data_of(32'h100));
        mem_delay = 3;
        fetch_en  = 1;
        wait_acc(6, "redir_wait");
        mem_delay      = 0;
        redirect_valid = 1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 0;
        wait_acc(7, "redir_wait_next");
        drain("redir_wait");
    endtask

    task automatic test_redirect_resp();
        exp_addr_q.push_back(32'h104);
        exp_addr_q.push_back(32'h200);
        exp_data_q.push_back(data_of(32'h200));
        fetch_en = 1;
        wait_acc(8, "redir_resp");
        redirect_valid = 1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        n_cmp++;
        if (buf_write_en !== 1'b0) begin n_err++; $display("FAIL redir_resp_no_write: got=%b want=0", buf_write_en); end
        tick();
        redirect_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_err++;
            $display("FAIL redir_resp_target: got=%b/%h want=1/00000200", imem_req_valid, imem_req_addr);
        end
        wait_acc(9, "redir_resp_next");
        drain("redir_resp");
    endtask

    task automatic test_wrap_backpressure();
        exp_addr_q.push_back(32'hFFFFFFFC);
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(data_of(32'hFFFFFFFC));
        exp_data_q.push_back(data_of(32'h0));
        imem_req_ready = 0;
        redirect_valid = 1;
        redirect_pc    = 32'hFFFFFFFE;
        tick();
        redirect_valid = 0;
        fetch_en       = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC) begin
                n_err++;
                $display("FAIL wrap_stable[%0d]: got=%b/%h want=1/fffffffc", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1;
        wait_acc(11, "wrap");
        drain("wrap");
    endtask

    task automatic test_async_reset();
        exp_addr_q.push_back(32'h4);
        mem_delay = 3;
        fetch_en  = 1;
        wait_acc(12, "async_reset");
        #1;
        reset = 0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            n_err++;
            $display("FAIL async_rst_req: got=%b/%h want=0/00000000", imem_req_valid, imem_req_addr);
        end
        n_cmp++;
        if (buf_write_en !== 1'b0 || buf_data !== 32'h0) begin
            n_err++;
            $display("FAIL async_rst_buf: got=%b/%h want=0/00000000", buf_write_en, buf_data);
        end
        mem_delay = 0;
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(data_of(32'h0));
        tick();
        tick();
        reset = 1;
        wait_acc(13, "async_reset_restart");
        drain("async_reset");
    endtask

    initial begin
        reset = 0; fetch_en = 0; redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 1; buf_full = 0;
        test_reset();
        test_zero_wait();
        test_full_buffer();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
